// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter between the pipeline (A) and the mul/div unit (M), with a
// starvation override for M and a pending-write scoreboard for decode hazards.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,

    input  logic            m_valid,
    output logic            m_ready,
    input  logic [4:0]      m_rd,
    input  logic [XLEN-1:0] m_data,

    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [4:0]      iss_rd,

    input  logic [4:0]      rs1_q,
    input  logic [4:0]      rs2_q,
    output logic            rs1_busy,
    output logic            rs2_busy,

    output logic            we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,

    output logic            force_m
);

    typedef enum logic {
        ST_NORMAL,
        ST_FORCE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       pending_q, pending_d;
    logic              we_q, we_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]   rd_data_q, rd_data_d;

    logic a_xfer, m_xfer, iss_xfer, m_wait;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        a_ready = 1'b1;
        m_ready = ~a_valid | (a_rd == 5'd0);
        force_m = 1'b0;
        if (state_q == ST_FORCE) begin
            a_ready = 1'b0;
            m_ready = 1'b1;
            force_m = 1'b1;
        end
    end

    assign a_xfer   = a_valid & a_ready;
    assign m_xfer   = m_valid & m_ready;
    assign m_wait   = m_valid & ~m_ready;
    assign iss_ready = ~pending_q[iss_rd] | (m_xfer & (m_rd == iss_rd));
    assign iss_xfer = iss_valid & iss_ready;

    assign rs1_busy = pending_q[rs1_q];
    assign rs2_busy = pending_q[rs2_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        if (m_wait && cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
        end else if (m_wait) begin
            cnt_d = cnt_q;
        end
        case (state_q)
            ST_NORMAL: if (m_wait && cnt_q == 3'(STARVE_LIMIT - 1)) state_d = ST_FORCE;
            ST_FORCE:  if (m_xfer || !m_valid)                      state_d = ST_NORMAL;
            default:   state_d = ST_NORMAL;
        endcase
    end

    // M takes priority on the write port; A only shares a cycle with M when a_rd is x0.
    always_comb begin
        we_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (m_xfer && m_rd != 5'd0) begin
            we_d      = 1'b1;
            rd_addr_d = m_rd;
            rd_data_d = m_data;
        end else if (a_xfer && a_rd != 5'd0) begin
            we_d      = 1'b1;
            rd_addr_d = a_rd;
            rd_data_d = a_data;
        end
    end

    // Clear before set so a same-cycle re-issue of the completing register stays pending.
    always_comb begin
        pending_d = pending_q;
        if (m_xfer)                       pending_d[m_rd]   = 1'b0;
        if (iss_xfer && iss_rd != 5'd0)   pending_d[iss_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    // NOTE: the scoreboard is a flop vector rather than a RAM, so it is reset
    // along with everything else and hazards clear immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_NORMAL;
            cnt_q     <= 3'd0;
            pending_q <= '0;
            we_q      <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign we      = we_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: write port, x0, starvation override,
// scoreboard and reset-in-FORCE scenarios with hand-computed expectations.
module tb_regfile_wb_arbiter;

    logic        clk, rst_n;
    logic        a_valid, a_ready;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        m_valid, m_ready;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1_q, rs2_q;
    logic        rs1_busy, rs2_busy;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        force_m;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf [32];
    logic        x0_written = 1'b0;

    regfile_wb_arbiter #(.STARVE_LIMIT(4), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .rs1_q(rs1_q), .rs2_q(rs2_q), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .we(we), .rd_addr(rd_addr), .rd_data(rd_data), .force_m(force_m)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file shadow fed from the write port.
    always @(negedge clk) begin
        if (rst_n && we) begin
            if (rd_addr == 5'd0) x0_written = 1'b1;
            rf[rd_addr] = rd_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        a_valid = 0; m_valid = 0; iss_valid = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst_n = 0;
        a_valid = 0; a_rd = 0; a_data = 0;
        m_valid = 0; m_rd = 0; m_data = 0;
        iss_valid = 0; iss_rd = 0; rs1_q = 0; rs2_q = 0;
        @(negedge clk);
        #1;
        check("rst_we",      we, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_force",   force_m, 0);
        check("rst_a_ready", a_ready, 1);
        @(negedge clk);
        rst_n = 1;

        // Pipeline write of x1
        a_valid = 1; a_rd = 1; a_data = 32'hA5A5_A5A5;
        #1 check("a_ready_normal", a_ready, 1);
        tick(); idle();
        check("a_we",      we, 1);
        check("a_rd_addr", rd_addr, 1);
        check("a_rd_data", rd_data, 32'hA5A5_A5A5);
        tick();
        check("idle_we",      we, 0);
        check("hold_rd_addr", rd_addr, 1);
        check("hold_rd_data", rd_data, 32'hA5A5_A5A5);

        // A to x0 alongside M to x3: both accepted, only M writes
        a_valid = 1; a_rd = 0; a_data = 32'hFFFF_FFFF;
        m_valid = 1; m_rd = 3; m_data = 32'h3333_3333;
        #1 check("x0_m_ready", m_ready, 1);
        check("x0_a_ready", a_ready, 1);
        tick(); idle();
        check("x0_m_we",      we, 1);
        check("x0_m_rd_addr", rd_addr, 3);
        check("x0_m_rd_data", rd_data, 32'h3333_3333);
        tick();
        check("x0_after_we", we, 0);

        // Starvation: A holds x5, M waits four cycles then is forced through
        a_valid = 1; a_rd = 5; a_data = 32'h5555_5555;
        m_valid = 1; m_rd = 7; m_data = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            #1 check("starve_m_ready", m_ready, 0);
            check("starve_force", force_m, 0);
            tick();
            check("starve_a_we", we, 1);
            check("starve_a_rd", rd_addr, 5);
        end
        #1 check("force_on",      force_m, 1);
        check("force_a_ready", a_ready, 0);
        check("force_m_ready", m_ready, 1);
        tick(); idle();
        check("force_m_we",   we, 1);
        check("force_m_rd",   rd_addr, 7);
        check("force_m_data", rd_data, 32'h7777_7777);
        check("force_exit",   force_m, 0);
        check("exit_a_ready", a_ready, 1);
        tick();

        // Scoreboard: issue x9 then try again
        iss_valid = 1; iss_rd = 9;
        #1 check("iss9_ready", iss_ready, 1);
        tick(); idle();
        rs1_q = 9; rs2_q = 0;
        #1 check("rs1_busy_9", rs1_busy, 1);
        check("rs2_busy_0", rs2_busy, 0);
        iss_valid = 1; iss_rd = 9;
        #1 check("iss9_dup_ready", iss_ready, 0);
        iss_valid = 0;

        // M completes x9 while x9 is re-issued: set wins
        m_valid = 1; m_rd = 9; m_data = 32'h9999_9999;
        iss_valid = 1; iss_rd = 9;
        #1 check("reiss_ready",   iss_ready, 1);
        check("reiss_m_ready", m_ready, 1);
        tick(); idle();
        check("reiss_we",   we, 1);
        check("reiss_rd",   rd_addr, 9);
        check("reiss_data", rd_data, 32'h9999_9999);
        #1 check("reiss_busy", rs1_busy, 1);
        m_valid = 1; m_rd = 9; m_data = 32'h9999_0000;
        tick(); idle();
        #1 check("clear_busy", rs1_busy, 0);

        // Reset during FORCE with x2, x4, x6 pending
        for (int r = 2; r <= 6; r += 2) begin
            iss_valid = 1; iss_rd = 5'(r);
            tick();
        end
        iss_valid = 0;
        rs1_q = 2; rs2_q = 4;
        #1 check("pend_x2", rs1_busy, 1);
        check("pend_x4", rs2_busy, 1);
        a_valid = 1; a_rd = 5; a_data = 32'h0000_5A5A;
        m_valid = 1; m_rd = 2; m_data = 32'h2222_2222;
        repeat (4) tick();
        #1 check("rst_pre_force", force_m, 1);
        check("rst_pre_we", we, 1);
        rst_n = 0;
        #1 check("rstf_force",   force_m, 0);
        check("rstf_we",      we, 0);
        check("rstf_rd_addr", rd_addr, 0);
        check("rstf_rd_data", rd_data, 0);
        check("rstf_busy1",   rs1_busy, 0);
        check("rstf_busy2",   rs2_busy, 0);
        rs1_q = 6;
        #1 check("rstf_busy6",   rs1_busy, 0);
        check("rstf_m_ready", m_ready, 0);
        check("rstf_a_ready", a_ready, 1);
        idle();
        @(negedge clk);
        rst_n = 1;
        a_valid = 1; a_rd = 10; a_data = 32'h1010_1010;
        tick(); idle();
        check("post_rst_we", we, 1);
        check("post_rst_rd", rd_addr, 10);
        tick();

        check("rf_x1",      rf[1], 32'hA5A5_A5A5);
        check("rf_x7",      rf[7], 32'h7777_7777);
        check("x0_written", x0_written, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
